// File: rtl/cpr_stream_packer.sv
// cpr_stream_packer
//   Packs variable-length compressed records (0..IN_BYTES bytes each) back to
//   back into OUT_BYTES-wide output beats with per-byte keep, using ready/valid
//   handshakes on both sides. A record flagged in_tlast closes the packet: the
//   remaining bytes are flushed as a final (possibly partial) beat with
//   out_tlast. Oversized lengths are clamped and flagged on the sticky len_err.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_tdata/in_len     record bytes (byte k at [8k+7:8k]) and length in bytes
//   in_tlast            record ends the packet
//   in_tvalid/in_tready record handshake
//   out_tdata/out_tkeep packed beat (byte 0 oldest), contiguous keep from bit 0
//   out_tlast           last beat of the packet
//   out_tvalid/out_tready beat handshake
//   beat_count          beats transferred since reset (wrapping)
//   len_err             sticky: a record arrived with in_len > IN_BYTES
module cpr_stream_packer #(
  parameter int unsigned IN_BYTES  = 34,
  parameter int unsigned OUT_BYTES = 32,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*IN_BYTES-1:0]  in_tdata,
  input  logic [LEN_WIDTH-1:0]   in_len,
  input  logic                   in_tlast,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic [8*OUT_BYTES-1:0] out_tdata,
  output logic [OUT_BYTES-1:0]   out_tkeep,
  output logic                   out_tlast,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [CNT_WIDTH-1:0]   beat_count,
  output logic                   len_err
);

  localparam int unsigned BUF_BYTES = OUT_BYTES + IN_BYTES;
  localparam int unsigned BUF_W     = 8 * BUF_BYTES;
  localparam int unsigned FILL_W    = $clog2(BUF_BYTES + 1);

  typedef enum logic {ACC, FLUSH} state_t;

  state_t                 state, state_next;
  logic [FILL_W-1:0]      fill, fill_next, avail, acc_len, emitted;
  logic [BUF_W-1:0]       buf_q, merged, buf_next, rec_ext;
  logic [8*IN_BYTES-1:0]  rec_masked;
  logic [LEN_WIDTH-1:0]   len_c;
  logic [OUT_BYTES-1:0]   keep_next;
  logic                   len_over, accept, can_load, ending, full, load, load_last;

  assign in_tready = !reset && (state == ACC) && (fill < FILL_W'(OUT_BYTES));

  // Emission looks at the buffer with this cycle's record already merged in,
  // so a record that completes a beat is visible on the next cycle and a
  // steady stream of records of at most OUT_BYTES never stalls the input.
  // Buffer bytes at and above fill are always zero, which keeps the merge a
  // plain OR and the unused bytes of a partial beat zero.
  always_comb begin
    len_over = in_len > LEN_WIDTH'(IN_BYTES);
    len_c    = len_over ? LEN_WIDTH'(IN_BYTES) : in_len;
    accept   = in_tvalid && in_tready;
    acc_len  = accept ? FILL_W'(len_c) : '0;

    rec_masked = '0;
    for (int unsigned k = 0; k < IN_BYTES; k++) begin
      if (LEN_WIDTH'(k) < len_c) rec_masked[8*k +: 8] = in_tdata[8*k +: 8];
    end
    rec_ext = BUF_W'(rec_masked);

    merged   = buf_q | (accept ? (rec_ext << {fill, 3'b000}) : '0);
    avail    = fill + acc_len;
    ending   = (state == FLUSH) || (accept && in_tlast);
    can_load = !out_tvalid || out_tready;
    full     = avail >= FILL_W'(OUT_BYTES);

    // A packet end with nothing buffered still loads: a keep=0 tlast beat.
    load      = can_load && (full || ending);
    load_last = ending && (avail <= FILL_W'(OUT_BYTES));

    emitted = '0;
    if (load) emitted = full ? FILL_W'(OUT_BYTES) : avail;

    keep_next = '0;
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      keep_next[i] = FILL_W'(i) < avail;
    end

    buf_next  = merged >> {emitted, 3'b000};
    fill_next = avail - emitted;

    state_next = state;
    if (load && load_last)        state_next = ACC;
    else if (accept && in_tlast)  state_next = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACC;
      fill       <= '0;
      buf_q      <= '0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
      beat_count <= '0;
      len_err    <= 1'b0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      buf_q <= buf_next;

      if (load) begin
        out_tdata  <= merged[8*OUT_BYTES-1:0];
        out_tkeep  <= keep_next;
        out_tlast  <= load_last;
        out_tvalid <= 1'b1;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end

      if (out_tvalid && out_tready) beat_count <= beat_count + CNT_WIDTH'(1);
      if (accept && len_over)       len_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpr_stream_packer.sv
module tb_cpr_stream_packer;

  localparam int IB = 34;
  localparam int OB = 32;
  localparam int LW = 8;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [8*IB-1:0] in_tdata;
  logic [LW-1:0]   in_len;
  logic            in_tlast;
  logic            in_tvalid;
  logic            in_tready;
  logic [8*OB-1:0] out_tdata;
  logic [OB-1:0]   out_tkeep;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready;
  logic [CW-1:0]   beat_count;
  logic            len_err;

  always #5 clk = ~clk;

  cpr_stream_packer #(
    .IN_BYTES (IB),
    .OUT_BYTES(OB),
    .LEN_WIDTH(LW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_tdata  (in_tdata),
    .in_len    (in_len),
    .in_tlast  (in_tlast),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .beat_count(beat_count),
    .len_err   (len_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Beat collector: handshake observed at negedge completes on the next posedge.
  logic [255:0] q_data[$];
  logic [31:0]  q_keep[$];
  logic         q_last[$];

  always @(negedge clk) begin
    if (reset === 1'b0 && out_tvalid === 1'b1 && out_tready === 1'b1) begin
      q_data.push_back(out_tdata);
      q_keep.push_back(out_tkeep);
      q_last.push_back(out_tlast);
    end
  end

  function automatic logic [255:0] seq_beat(input int first, input int count);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < count; k++) r[k*8 +: 8] = 8'(first + k);
    return r;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the record was accepted.
  task automatic send(input int len, input int start, input logic last);
    int cyc;
    cyc = 0;
    for (int k = 0; k < IB; k++) in_tdata[k*8 +: 8] = (k < len) ? 8'(start + k) : 8'hEE;
    in_len    = 8'(len);
    in_tlast  = last;
    in_tvalid = 1'b1;
    @(negedge clk);
    while (in_tready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("send_timeout", in_tready, 1'b1);
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int cyc;
    cyc = 0;
    while (q_data.size() < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_beat(input string tag, input logic [255:0] d, input logic [31:0] k, input logic l);
    chk({tag, "_present"}, (q_data.size() > 0), 1'b1);
    if (q_data.size() > 0) begin
      chk({tag, "_data"}, q_data.pop_front(), d);
      chk({tag, "_keep"}, q_keep.pop_front(), k);
      chk({tag, "_last"}, q_last.pop_front(), l);
    end
  endtask

  task automatic check_idle(input string tag);
    repeat (6) @(negedge clk);
    chk(tag, q_data.size(), 0);
  endtask

  logic [255:0] snap_d;
  logic [31:0]  snap_k;
  logic         snap_l;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    in_tvalid  = 1'b1;
    in_len     = 8'd20;
    in_tlast   = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b1;

    // Reset held with a valid record pending.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_tready", in_tready, 1'b0);
      chk("rst_out_tvalid", out_tvalid, 1'b0);
      chk("rst_out_tdata", out_tdata, '0);
      chk("rst_out_tkeep", out_tkeep, '0);
      chk("rst_out_tlast", out_tlast, 1'b0);
      chk("rst_beat_count", beat_count, '0);
      chk("rst_len_err", len_err, 1'b0);
    end
    reset     = 1'b0;
    in_tvalid = 1'b0;
    #1;
    chk("rel_in_tready", in_tready, 1'b1);
    @(posedge clk);
    #1;

    // Two len-20 records, second closes the packet.
    send(20, 8'h00, 1'b0);
    send(20, 8'h20, 1'b1);
    wait_beats(2);
    check_beat("t2_b1", seq_beat(0, 20) | (seq_beat(32'h20, 12) << 160), 32'hFFFF_FFFF, 1'b0);
    check_beat("t2_b2", seq_beat(32'h2C, 8), 32'h0000_00FF, 1'b1);
    check_idle("t2_extra");
    chk("t2_beat_count", beat_count, 2);

    // Three full-length records then an empty tlast record: 102 bytes.
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) send(34, 34 * r, 1'b0);
    send(0, 8'h00, 1'b1);
    wait_beats(4);
    for (int j = 0; j < 3; j++) check_beat("t3_full", seq_beat(32 * j, 32), 32'hFFFF_FFFF, 1'b0);
    check_beat("t3_tail", seq_beat(96, 6), 32'h0000_003F, 1'b1);
    check_idle("t3_extra");

    // Packet of exactly one beat, then an empty packet.
    @(posedge clk);
    #1;
    send(16, 8'h40, 1'b0);
    send(16, 8'h50, 1'b1);
    wait_beats(1);
    check_beat("t4_exact", seq_beat(32'h40, 32), 32'hFFFF_FFFF, 1'b1);
    check_idle("t4_extra");
    @(posedge clk);
    #1;
    send(0, 8'h99, 1'b1);
    wait_beats(1);
    check_beat("t4_empty", '0, 32'h0, 1'b1);
    check_idle("t4_empty_extra");

    // Output stall in the middle of a stream of full-length records.
    @(posedge clk);
    #1;
    fork
      begin
        for (int r = 0; r < 6; r++) send(34, 34 * r, (r == 5));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_tready = 1'b0;
        @(negedge clk);
        chk("t5_stall_valid", out_tvalid, 1'b1);
        snap_d = out_tdata;
        snap_k = out_tkeep;
        snap_l = out_tlast;
        repeat (10) begin
          @(negedge clk);
          chk("t5_hold_valid", out_tvalid, 1'b1);
          chk("t5_hold_data", out_tdata, snap_d);
          chk("t5_hold_keep", out_tkeep, snap_k);
          chk("t5_hold_last", out_tlast, snap_l);
        end
        chk("t5_in_tready_low", in_tready, 1'b0);
        out_tready = 1'b1;
      end
    join
    wait_beats(7);
    for (int j = 0; j < 6; j++) check_beat("t5_full", seq_beat(32 * j, 32), 32'hFFFF_FFFF, 1'b0);
    check_beat("t5_tail", seq_beat(192, 12), 32'h0000_0FFF, 1'b1);
    check_idle("t5_extra");

    // Oversized length: clamped, sticky error.
    @(posedge clk);
    #1;
    chk("t6_len_err_pre", len_err, 1'b0);
    send(40, 8'h80, 1'b1);
    wait_beats(2);
    check_beat("t6_b1", seq_beat(32'h80, 32), 32'hFFFF_FFFF, 1'b0);
    check_beat("t6_b2", seq_beat(32'hA0, 2), 32'h0000_0003, 1'b1);
    chk("t6_len_err_set", len_err, 1'b1);
    @(posedge clk);
    #1;
    send(4, 8'hC0, 1'b1);
    wait_beats(1);
    check_beat("t6_good", seq_beat(32'hC0, 4), 32'h0000_000F, 1'b1);
    check_idle("t6_extra");
    chk("t6_len_err_sticky", len_err, 1'b1);
    chk("t6_beat_count", beat_count, 18);

    // Reset in the middle of a packet discards the buffered bytes.
    @(posedge clk);
    #1;
    send(10, 8'h60, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t7_out_tvalid", out_tvalid, 1'b0);
    chk("t7_beat_count", beat_count, '0);
    chk("t7_len_err", len_err, 1'b0);
    send(3, 8'h70, 1'b1);
    wait_beats(1);
    check_beat("t7_after", seq_beat(32'h70, 3), 32'h0000_0007, 1'b1);
    check_idle("t7_extra");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
